// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - measurement request/result bundle between a controller and freq_meter
interface freq_meter_if #(
  parameter int CNT_W = 27
);
  logic             start;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             overflow;

  modport master (output start, input busy, count, valid, overflow);
  modport slave  (input start, output busy, count, valid, overflow);
endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts sig_in rising edges over a GATE_CYCLES clk window
// Define FREQ_METER_CONT_EN for back-to-back continuous measurement after the first start.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int GATE_W      = 27,
  parameter int CNT_W       = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_in,
  freq_meter_if.slave  bus
);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              edge_det;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf_int;
  logic              gate_last;
  logic              win_clear;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              ovf_q;

  assign edge_det  = s2 & ~s3;
  assign gate_last = (gate_cnt == GATE_LAST);

  always_comb begin
    state_nxt = state;
    win_clear = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = MEASURE;
          win_clear = 1'b1;
        end
      end
      MEASURE: begin
        if (gate_last) state_nxt = DONE;
      end
      DONE: begin
`ifdef FREQ_METER_CONT_EN
        state_nxt = MEASURE;
        win_clear = 1'b1;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
    end else begin
      state <= state_nxt;
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
    end
  end

  // Edge counter saturates; further edges only mark the window as overflowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
    end else if (win_clear) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_int  <= 1'b0;
    end else if (state == MEASURE) begin
      if (!gate_last) gate_cnt <= gate_cnt + 1'b1;
      if (edge_det) begin
        if (edge_cnt == CNT_MAX) ovf_int  <= 1'b1;
        else                     edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state == DONE) begin
      count_q <= edge_cnt;
      ovf_q   <= ovf_int;
      valid_q <= 1'b1;
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.count    = count_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed bench for freq_meter (continuous checks when FREQ_METER_CONT_EN is defined)
module tb_freq_meter;

  logic clk;
  logic rst_n;
  logic sig_in;
  int   half_per;
  int   ph;
  int   tests;
  int   fails;

  freq_meter_if #(.CNT_W(27)) bus_a ();
  freq_meter_if #(.CNT_W(3))  bus_b ();

  freq_meter #(.GATE_CYCLES(100), .GATE_W(7), .CNT_W(27)) dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus_a)
  );
  freq_meter #(.GATE_CYCLES(100), .GATE_W(7), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square wave with half period half_per clk cycles; 0 holds sig_in low.
  initial begin
    sig_in = 1'b0;
    ph     = 0;
    forever begin
      @(negedge clk);
      if (half_per > 0) begin
        ph++;
        if (ph >= half_per) begin
          sig_in = ~sig_in;
          ph     = 0;
        end
      end else begin
        sig_in = 1'b0;
        ph     = 0;
      end
    end
  end

  task automatic pulse_start(input bit b);
    if (b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic busy_len(input bit b, output int n);
    n = 0;
    while ((b ? bus_b.busy : bus_a.busy) === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bit bad;
    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    half_per = 2;
    repeat (5) @(negedge clk);
    tests++;
    if (bus_a.busy !== 1'b0 || bus_a.valid !== 1'b0 || bus_a.count !== 27'd0 || bus_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: busy=%b valid=%b count=%0d ovf=%b required all 0", bus_a.busy, bus_a.valid, bus_a.count, bus_a.overflow);
    end
    tests++;
    if (bus_b.busy !== 1'b0 || bus_b.valid !== 1'b0 || bus_b.count !== 3'd0 || bus_b.overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: busy=%b valid=%b count=%0d ovf=%b required all 0", bus_b.busy, bus_b.valid, bus_b.count, bus_b.overflow);
    end
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_a.busy !== 1'b0 || bus_a.valid !== 1'b0 || bus_a.count !== 27'd0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL idle_hold: outputs changed without start, required busy=0 valid=0 count=0");
    end
  endtask

  task automatic test_basic;
    int  n;
    bit  bad;
    half_per = 5;
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    busy_len(1'b0, n);
    tests++;
    if (n !== 101) begin
      fails++;
      $display("FAIL basic_busy: busy cycles %0d required 101", n);
    end
    tests++;
    if (bus_a.valid !== 1'b1 || bus_a.count !== 27'd10 || bus_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_count: valid=%b count=%0d ovf=%b required 1/10/0", bus_a.valid, bus_a.count, bus_a.overflow);
    end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_a.valid !== 1'b1 || bus_a.count !== 27'd10 || bus_a.busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL basic_hold: result changed, count=%0d required 10 held", bus_a.count);
    end
  endtask

  task automatic test_no_input;
    int n;
    half_per = 0;
    repeat (10) @(negedge clk);
    pulse_start(1'b0);
    busy_len(1'b0, n);
    tests++;
    if (bus_a.valid !== 1'b1 || bus_a.count !== 27'd0) begin
      fails++;
      $display("FAIL no_input: valid=%b count=%0d required 1/0", bus_a.valid, bus_a.count);
    end
    half_per = 2;
    repeat (20) @(negedge clk);
    pulse_start(1'b0);
    tests++;
    if (bus_a.valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_clear: valid=%b required 0 after start", bus_a.valid);
    end
    busy_len(1'b0, n);
    tests++;
    if (bus_a.valid !== 1'b1 || bus_a.count !== 27'd25) begin
      fails++;
      $display("FAIL period4_count: valid=%b count=%0d required 1/25", bus_a.valid, bus_a.count);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    half_per = 5;
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    busy_len(1'b0, n);
    pulse_start(1'b0);
    tests++;
    if (bus_a.busy !== 1'b1 || bus_a.valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_restart: busy=%b valid=%b required 1/0", bus_a.busy, bus_a.valid);
    end
    busy_len(1'b0, n);
    tests++;
    if (n !== 101 || bus_a.count !== 27'd10 || bus_a.valid !== 1'b1) begin
      fails++;
      $display("FAIL b2b_count: busy %0d count=%0d required 101/10", n, bus_a.count);
    end
  endtask

  task automatic test_saturation;
    int n;
    half_per = 5;
    repeat (30) @(negedge clk);
    pulse_start(1'b1);
    busy_len(1'b1, n);
    tests++;
    if (bus_b.count !== 3'd7 || bus_b.overflow !== 1'b1 || bus_b.valid !== 1'b1) begin
      fails++;
      $display("FAIL sat_count: count=%0d ovf=%b required 7/1", bus_b.count, bus_b.overflow);
    end
    half_per = 25;
    repeat (120) @(negedge clk);
    pulse_start(1'b1);
    tests++;
    if (bus_b.overflow !== 1'b0 || bus_b.valid !== 1'b0) begin
      fails++;
      $display("FAIL sat_clear: ovf=%b valid=%b required 0/0 after start", bus_b.overflow, bus_b.valid);
    end
    busy_len(1'b1, n);
    tests++;
    if (bus_b.count !== 3'd2 || bus_b.overflow !== 1'b0) begin
      fails++;
      $display("FAIL sat_slow: count=%0d ovf=%b required 2/0", bus_b.count, bus_b.overflow);
    end
  endtask

  task automatic test_abort_ignore;
    int n;
    half_per = 5;
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (bus_a.busy !== 1'b0 || bus_a.valid !== 1'b0 || bus_a.count !== 27'd0 || bus_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL abort: busy=%b valid=%b count=%0d ovf=%b required all 0", bus_a.busy, bus_a.valid, bus_a.count, bus_a.overflow);
    end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (bus_a.busy !== 1'b0 || bus_a.valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b valid=%b required 0/0", bus_a.busy, bus_a.valid);
    end
    pulse_start(1'b0);
    n = 0;
    while (bus_a.busy === 1'b1 && n < 400) begin
      n++;
      bus_a.start = (n == 10 || n == 50);
      @(negedge clk);
    end
    bus_a.start = 1'b0;
    tests++;
    if (n !== 101 || bus_a.count !== 27'd10) begin
      fails++;
      $display("FAIL ignore_start: busy %0d count=%0d required 101/10", n, bus_a.count);
    end
  endtask

  task automatic test_continuous;
    int  n;
    bit  bad;
    half_per = 5;
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    n = 0;
    while (bus_a.valid !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 101 || bus_a.count !== 27'd10) begin
      fails++;
      $display("FAIL cont_first: cycles %0d count=%0d required 101/10", n, bus_a.count);
    end
    for (int w = 0; w < 5; w++) begin
      bad = 1'b0;
      for (int i = 0; i < 101; i++) begin
        @(negedge clk);
        if (bus_a.busy !== 1'b1 || bus_a.valid !== 1'b1) bad = 1'b1;
      end
      tests++;
      if (bad || bus_a.count !== 27'd10) begin
        fails++;
        $display("FAIL cont_window%0d: busy/valid dropped=%b count=%0d required 10", w, bad, bus_a.count);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    half_per = 0;
    rst_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    test_reset();
`ifdef FREQ_METER_CONT_EN
    test_continuous();
`else
    test_basic();
    test_no_input();
    test_back_to_back();
    test_saturation();
    test_abort_ignore();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
